decode_regfile_pipe: RTL and testbench

Parametrised decode stage for the pipelined MIPS CPU: register file, operand read with write-back bypass, immediate extension, destination select, and an ID/EX output register with a valid/ready handshake and flush. Sits between fetch (instruction plus PC+4 in) and execute (operands, immediate and destination out). Generalises the single-cycle decoder with configurable width and depth, a hardwired zero register, LUI support, stall-safe operand refresh and pipeline flush.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/regfile_2r1w.sv | 56 +++++
 rtl/decode_regfile_pipe.sv | 183 ++++++++++++++++++
 tb/tb_decode_regfile_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants and immediate-extension kinds.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [1:0] {
        SIGN  = 2'd0,
        ZERO  = 2'd1,
        UPPER = 2'd2
    } imm_kind;

    function automatic imm_kind imm_kind_of(input logic [5:0] opcode);
        imm_kind kind;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: kind = ZERO;
            OP_LUI:                   kind = UPPER;
            default:                  kind = SIGN;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with a hardwired zero register and
// write-to-read bypass so a same-cycle write-back is seen by the readers.
module regfile_2r1w #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [NREG];

    // Array write; register 0 is never stored so it stays zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port A with zero register and bypass.
    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i == '0) begin
            rdata_a_o = '0;
        end else if (we_i && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end else begin
            rdata_a_o = mem_q[raddr_a_i];
        end
    end

    // Read port B with zero register and bypass.
    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i == '0) begin
            rdata_b_o = '0;
        end else if (we_i && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end else begin
            rdata_b_o = mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/decode_regfile_pipe.sv
// MIPS decode stage: field split, register read with bypass, immediate extension,
// destination select and an ID/EX register with valid/ready handshake and flush.
module decode_regfile_pipe
    import mips_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NREG     = 32,
    parameter  int LINK_REG = 31,
    localparam int ADDR_W   = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [ADDR_W-1:0] out_dest,
    output logic [5:0]        out_opcode,
    output logic [5:0]        out_funct,
    output logic [DATA_W-1:0] out_pc_plus4
);

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [15:0]       imm16_s;
    logic signed [31:0] upper_s;
    logic [ADDR_W-1:0] rs_idx_s, rt_idx_s, rd_idx_s;
    logic [DATA_W-1:0] rs_rd_s, rt_rd_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic [ADDR_W-1:0] dest_s;
    logic              accept_s;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [5:0]        funct_q, funct_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rs_idx_q, rs_idx_d;
    logic [ADDR_W-1:0] rt_idx_q, rt_idx_d;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk_i     (clock),
        .rst_i     (reset),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_idx_s),
        .raddr_b_i (rt_idx_s),
        .rdata_a_o (rs_rd_s),
        .rdata_b_o (rt_rd_s)
    );

    // Field split, immediate extension and destination select.
    always_comb begin
        opcode_s = instruction[31:26];
        funct_s  = instruction[5:0];
        imm16_s  = instruction[15:0];
        upper_s  = {instruction[15:0], 16'h0000};
        rs_idx_s = ADDR_W'(instruction[25:21]);
        rt_idx_s = ADDR_W'(instruction[20:16]);
        rd_idx_s = ADDR_W'(instruction[15:11]);

        // Casting a signed value to DATA_W sign-extends; LUI uses bit 31 as sign.
        case (imm_kind_of(opcode_s))
            ZERO:    imm_ext_s = DATA_W'(imm16_s);
            UPPER:   imm_ext_s = DATA_W'(upper_s);
            default: imm_ext_s = DATA_W'($signed(imm16_s));
        endcase

        case (opcode_s)
            OP_RTYPE: begin
                if (funct_s == FN_JR) begin
                    dest_s = '0;
                end else begin
                    dest_s = rd_idx_s;
                end
            end
            OP_JAL:                    dest_s = ADDR_W'(LINK_REG);
            OP_J, OP_BEQ, OP_BNE, OP_SW: dest_s = '0;
            default:                   dest_s = rt_idx_s;
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign accept_s = in_valid && in_ready && !flush;

    // ID/EX next state: flush beats accept, accept beats drain/stall.
    always_comb begin
        valid_d   = valid_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        dest_d    = dest_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        pc_d      = pc_q;
        rs_idx_d  = rs_idx_q;
        rt_idx_d  = rt_idx_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d   = 1'b1;
            rs_data_d = rs_rd_s;
            rt_data_d = rt_rd_s;
            imm_d     = imm_ext_s;
            dest_d    = dest_s;
            opcode_d  = opcode_s;
            funct_d   = funct_s;
            pc_d      = pc_plus4;
            rs_idx_d  = rs_idx_s;
            rt_idx_d  = rt_idx_s;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: keep held operands current with late write-backs.
            if (wb_en && (wb_addr != '0) && (wb_addr == rs_idx_q)) begin
                rs_data_d = wb_data;
            end else begin
                rs_data_d = rs_data_q;
            end
            if (wb_en && (wb_addr != '0) && (wb_addr == rt_idx_q)) begin
                rt_data_d = wb_data;
            end else begin
                rt_data_d = rt_data_q;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // ID/EX register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            dest_q    <= '0;
            opcode_q  <= 6'h00;
            funct_q   <= 6'h00;
            pc_q      <= '0;
            rs_idx_q  <= '0;
            rt_idx_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            dest_q    <= dest_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            pc_q      <= pc_d;
            rs_idx_q  <= rs_idx_d;
            rt_idx_q  <= rt_idx_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_rs_data  = rs_data_q;
    assign out_rt_data  = rt_data_q;
    assign out_imm      = imm_q;
    assign out_dest     = dest_q;
    assign out_opcode   = opcode_q;
    assign out_funct    = funct_q;
    assign out_pc_plus4 = pc_q;

endmodule

// File: tb/tb_decode_regfile_pipe.sv
// Bench for decode_regfile_pipe (64-bit, 64 registers): directed vector table,
// reset corner cases, then randomized traffic against a behavioural model.
module tb_decode_regfile_pipe;

    localparam int DW = 64;
    localparam int NR = 64;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instruction = 32'h0;
    logic [DW-1:0] pc_plus4 = '0;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_rs_data, out_rt_data, out_imm, out_pc_plus4;
    logic [AW-1:0] out_dest;
    logic [5:0]    out_opcode, out_funct;

    always #5 clock = ~clock;

    decode_regfile_pipe #(.DATA_W(DW), .NREG(NR), .LINK_REG(31)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_plus4(pc_plus4), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
        .out_dest(out_dest), .out_opcode(out_opcode), .out_funct(out_funct),
        .out_pc_plus4(out_pc_plus4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [63:0] pc;
        logic        we;
        logic [5:0]  wa;
        logic [63:0] wd;
        logic        fl;
        logic        ordy;
        logic        e_rdy;
        logic        e_val;
        logic [63:0] e_rs;
        logic [63:0] e_rt;
        logic [63:0] e_imm;
        logic [5:0]  e_dst;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vt [16];

    // Behavioural model state
    logic [63:0] m_regs [NR];
    logic        m_valid;
    logic [63:0] m_rs, m_rt, m_imm, m_pc;
    logic [5:0]  m_dest, m_op, m_fn, m_rs_idx, m_rt_idx;

    function automatic logic [63:0] m_read(input logic [5:0] idx);
        if (idx == 6'd0) return 64'h0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic [63:0] m_immx(input logic [5:0] op, input logic [15:0] imm);
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {48'h0, imm};
        if (op == 6'h0F) return {{32{imm[15]}}, imm, 16'h0000};
        return {{48{imm[15]}}, imm};
    endfunction

    function automatic logic [5:0] m_dst(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'h00) return (ins[5:0] == 6'h08) ? 6'd0 : {1'b0, ins[15:11]};
        if (op == 6'h03) return 6'd31;
        if (op == 6'h02 || op == 6'h04 || op == 6'h05 || op == 6'h2B) return 6'd0;
        return {1'b0, ins[20:16]};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 64'h0;
        m_valid = 1'b0;
        m_rs = 64'h0; m_rt = 64'h0; m_imm = 64'h0; m_pc = 64'h0;
        m_dest = 6'h0; m_op = 6'h0; m_fn = 6'h0; m_rs_idx = 6'h0; m_rt_idx = 6'h0;
    endtask

    // One clock edge of the model, using the currently driven inputs.
    task automatic m_step();
        logic acc;
        acc = in_valid && (!m_valid || out_ready) && !flush;
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid  = 1'b1;
            m_rs_idx = {1'b0, instruction[25:21]};
            m_rt_idx = {1'b0, instruction[20:16]};
            m_rs     = m_read(m_rs_idx);
            m_rt     = m_read(m_rt_idx);
            m_imm    = m_immx(instruction[31:26], instruction[15:0]);
            m_dest   = m_dst(instruction);
            m_op     = instruction[31:26];
            m_fn     = instruction[5:0];
            m_pc     = pc_plus4;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end else if (m_valid && wb_en && wb_addr != 6'd0) begin
            if (wb_addr == m_rs_idx) m_rs = wb_data;
            if (wb_addr == m_rt_idx) m_rt = wb_data;
        end
        if (wb_en && wb_addr != 6'd0) m_regs[wb_addr] = wb_data;
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'h3408FFFF, 64'h1000, 1'b0, 6'd0,  64'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h0,        64'h0,        64'hFFFF,             6'd8,  64'h1000};
        vt[1]  = '{1'b1, 32'h01295020, 64'h1004, 1'b1, 6'd9,  64'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 64'hDEADBEEF, 64'hDEADBEEF, 64'h5020,             6'd10, 64'h1004};
        vt[2]  = '{1'b1, 32'h01295020, 64'h1008, 1'b1, 6'd41, 64'h1234,     1'b0, 1'b1, 1'b1, 1'b1, 64'hDEADBEEF, 64'hDEADBEEF, 64'h5020,             6'd10, 64'h1008};
        vt[3]  = '{1'b1, 32'h012A5822, 64'h100C, 1'b0, 6'd0,  64'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'hDEADBEEF, 64'h0,        64'h5822,             6'd11, 64'h100C};
        vt[4]  = '{1'b1, 32'h3408FFFF, 64'h1010, 1'b1, 6'd10, 64'h5,        1'b0, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF, 64'h5,        64'h5822,             6'd11, 64'h100C};
        vt[5]  = '{1'b1, 32'h3408FFFF, 64'h1014, 1'b1, 6'd11, 64'h77,       1'b0, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF, 64'h5,        64'h5822,             6'd11, 64'h100C};
        vt[6]  = '{1'b1, 32'h0C000010, 64'h00400008, 1'b0, 6'd0, 64'h0,     1'b0, 1'b1, 1'b1, 1'b1, 64'h0,        64'h0,        64'h10,               6'd31, 64'h00400008};
        vt[7]  = '{1'b1, 32'h00005020, 64'h1018, 1'b1, 6'd0,  64'h7,        1'b0, 1'b1, 1'b1, 1'b1, 64'h0,        64'h0,        64'h5020,             6'd10, 64'h1018};
        vt[8]  = '{1'b1, 32'h00005020, 64'h101C, 1'b0, 6'd0,  64'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h0,        64'h0,        64'h5020,             6'd10, 64'h101C};
        vt[9]  = '{1'b1, 32'h03E00008, 64'h1020, 1'b0, 6'd0,  64'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h0,        64'h0,        64'h8,                6'd0,  64'h1020};
        vt[10] = '{1'b1, 32'h3C088000, 64'h1024, 1'b0, 6'd0,  64'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h0,        64'h0,        64'hFFFFFFFF80000000, 6'd8,  64'h1024};
        vt[11] = '{1'b0, 32'h3408FFFF, 64'h1028, 1'b0, 6'd0,  64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h0,        64'h0,        64'hFFFFFFFF80000000, 6'd8,  64'h1024};
        vt[12] = '{1'b1, 32'h3408FFFF, 64'h1030, 1'b0, 6'd0,  64'h0,        1'b1, 1'b0, 1'b0, 1'b0, 64'h0,        64'h0,        64'h0,                6'd0,  64'h0};
        vt[13] = '{1'b0, 32'h3408FFFF, 64'h1034, 1'b0, 6'd0,  64'h0,        1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        64'h0,        64'h0,                6'd0,  64'h0};
        vt[14] = '{1'b1, 32'h01295020, 64'h1038, 1'b0, 6'd0,  64'h0,        1'b1, 1'b1, 1'b1, 1'b0, 64'h0,        64'h0,        64'h0,                6'd0,  64'h0};
        vt[15] = '{1'b0, 32'h01295020, 64'h103C, 1'b0, 6'd0,  64'h0,        1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        64'h0,        64'h0,                6'd0,  64'h0};

        // Reset state
        #12;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_ready", 64'(in_ready), 64'h1);
        check("rst_rs", out_rs_data, 64'h0);
        check("rst_imm", out_imm, 64'h0);
        check("rst_dest", 64'(out_dest), 64'h0);
        check("rst_pc", out_pc_plus4, 64'h0);
        @(negedge clock);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            in_valid = vt[i].iv; instruction = vt[i].ins; pc_plus4 = vt[i].pc;
            wb_en = vt[i].we; wb_addr = vt[i].wa; wb_data = vt[i].wd;
            flush = vt[i].fl; out_ready = vt[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_rdy));
            @(negedge clock);
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].e_val));
            if (vt[i].e_val) begin
                check($sformatf("v%0d_rs", i), out_rs_data, vt[i].e_rs);
                check($sformatf("v%0d_rt", i), out_rt_data, vt[i].e_rt);
                check($sformatf("v%0d_imm", i), out_imm, vt[i].e_imm);
                check($sformatf("v%0d_dest", i), 64'(out_dest), 64'(vt[i].e_dst));
                check($sformatf("v%0d_pc", i), out_pc_plus4, vt[i].e_pc);
            end
        end

        // Reset asserted mid-stall clears outputs without a clock edge
        in_valid = 1'b1; instruction = 32'h01295020; pc_plus4 = 64'h2000;
        wb_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        check("pre_rst_valid", 64'(out_valid), 64'h1);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_ready", 64'(in_ready), 64'h1);
        check("mid_rst_rs", out_rs_data, 64'h0);
        check("mid_rst_rt", out_rt_data, 64'h0);
        check("mid_rst_imm", out_imm, 64'h0);
        check("mid_rst_dest", 64'(out_dest), 64'h0);
        check("mid_rst_op", 64'(out_opcode), 64'h0);
        check("mid_rst_fn", 64'(out_funct), 64'h0);
        check("mid_rst_pc", out_pc_plus4, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        m_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] ops [12];
            logic [5:0] op;
            ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h2B, 6'h23};
            check("rnd_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                check("rnd_rs", out_rs_data, m_rs);
                check("rnd_rt", out_rt_data, m_rt);
                check("rnd_imm", out_imm, m_imm);
                check("rnd_dest", 64'(out_dest), 64'(m_dest));
                check("rnd_op", 64'(out_opcode), 64'(m_op));
                check("rnd_fn", 64'(out_funct), 64'(m_fn));
                check("rnd_pc", out_pc_plus4, m_pc);
            end
            op = ops[$urandom_range(0, 11)];
            instruction = {op, 26'($urandom)};
            if (op == 6'h00 && $urandom_range(0, 3) == 0) instruction[5:0] = 6'h08;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_addr   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : {1'b0, instruction[25:21] ^ 5'($urandom_range(0, 1))};
            wb_data   = {32'($urandom), 32'($urandom)};
            pc_plus4  = {32'($urandom), 32'($urandom)};
            #1;
            check("rnd_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            m_step();
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
